// File: rtl/matmul_sequencer_pkg.sv
// Shared types and sizing constants for the matrix-multiply sequencer.
package SystolicTypes;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_ADDR_W = 12;
    localparam int MEM_DEPTH      = 4096;
    localparam int ACC_W          = 2 * DEFAULT_WIDTH + 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] IDLE             = 3'd0;
    localparam logic [2:0] WAITING_MEMORY_A = 3'd1;
    localparam logic [2:0] WAITING_MEMORY_B = 3'd2;
    localparam logic [2:0] COMPUTE          = 3'd3;
    localparam logic [2:0] WRITEBACK        = 3'd4;

    function automatic int acc_width(input int w);
        return 2 * w + 8;
    endfunction

endpackage

// File: rtl/matmul_sequencer_mac.sv
// mac_unit: wide unsigned multiply-accumulator with a saturating WIDTH-bit view.
module mac_unit
    import SystolicTypes::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             saturated
);

    localparam int AW = acc_width(WIDTH);

    logic [AW-1:0]        acc_q;
    logic [2*WIDTH-1:0]   prod;

    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_q + AW'(prod);
        end
    end

    assign saturated = |acc_q[AW-1:WIDTH];
    assign result    = saturated ? '1 : acc_q[WIDTH-1:0];

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: sequences C = A*B over a synchronous-read data memory.
// Optional macro STEPPING_EN gates state advance on step rising edges.
module matmul_sequencer
    import SystolicTypes::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rst,
    input  logic              new_data,
    input  logic [ADDR_W-1:0] addr_A,
    input  logic [ADDR_W-1:0] addr_B,
    input  logic [ADDR_W-1:0] addr_C,
    input  logic [8:0]        matrix_N,
    input  logic              stepping_enable,
    input  logic              step,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output state_t            fsm_state,
    output logic [15:0]       cycle_count,
    output logic [31:0]       int_ops,
    output logic              op_done,
    output logic              overflow
);

    state_t           state_q;
    logic [8:0]       i_q, j_q, k_q;
    logic [8:0]       n_m1;
    logic [WIDTH-1:0] a_reg;
    logic             a_loaded;
    logic             new_data_q;
    logic             start;
    logic             adv;
    logic [13:0]      a_idx, b_idx, c_idx;
    logic [WIDTH-1:0] mac_result;
    logic             mac_sat;
    logic             mac_clear, mac_en;

`ifdef STEPPING_EN
    logic step_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_q <= 1'b0;
        else        step_q <= step;
    end
    assign adv = ~stepping_enable | (step & ~step_q);
`else
    logic step_unused;
    assign step_unused = stepping_enable | step;
    assign adv = 1'b1;
`endif

    assign n_m1  = matrix_N - 9'd1;
    assign start = new_data & ~new_data_q & (matrix_N != 9'd0);

    // Index products are formed at 14 bits before the address add truncates.
    assign a_idx = ({5'b0, i_q} * {5'b0, matrix_N}) + {5'b0, k_q};
    assign b_idx = ({5'b0, k_q} * {5'b0, matrix_N}) + {5'b0, j_q};
    assign c_idx = ({5'b0, i_q} * {5'b0, matrix_N}) + {5'b0, j_q};

    assign mac_clear = rst | ((state_q == IDLE) & start) | ((state_q == WRITEBACK) & adv);
    assign mac_en    = (state_q == COMPUTE) & adv & ~rst;

    mac_unit #(.WIDTH(WIDTH)) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (mac_clear),
        .en        (mac_en),
        .a         (a_reg),
        .b         (mem_rdata),
        .result    (mac_result),
        .saturated (mac_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            a_reg       <= '0;
            a_loaded    <= 1'b0;
            new_data_q  <= 1'b0;
            cycle_count <= '0;
            int_ops     <= '0;
            op_done     <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            // Tracking the level through a soft reset keeps a held request from restarting.
            new_data_q <= new_data;
            if (rst) begin
                state_q     <= IDLE;
                i_q         <= '0;
                j_q         <= '0;
                k_q         <= '0;
                a_reg       <= '0;
                a_loaded    <= 1'b0;
                cycle_count <= '0;
                int_ops     <= '0;
                op_done     <= 1'b0;
                overflow    <= 1'b0;
            end else begin
                if (state_q != IDLE && cycle_count != 16'hFFFF)
                    cycle_count <= cycle_count + 16'd1;
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            i_q         <= '0;
                            j_q         <= '0;
                            k_q         <= '0;
                            cycle_count <= '0;
                            int_ops     <= '0;
                            overflow    <= 1'b0;
                            op_done     <= 1'b0;
                            state_q     <= WAITING_MEMORY_A;
                        end
                    end
                    WAITING_MEMORY_A: begin
                        a_loaded <= 1'b0;
                        if (adv) state_q <= WAITING_MEMORY_B;
                    end
                    WAITING_MEMORY_B: begin
                        // A word is only on mem_rdata during the first cycle of the visit.
                        if (!a_loaded) begin
                            a_reg    <= mem_rdata;
                            a_loaded <= 1'b1;
                        end
                        if (adv) state_q <= COMPUTE;
                    end
                    COMPUTE: begin
                        if (adv) begin
                            int_ops <= int_ops + 32'd2;
                            if (k_q < n_m1) begin
                                k_q     <= k_q + 9'd1;
                                state_q <= WAITING_MEMORY_A;
                            end else begin
                                state_q <= WRITEBACK;
                            end
                        end
                    end
                    WRITEBACK: begin
                        if (adv) begin
                            if (mac_sat) overflow <= 1'b1;
                            k_q     <= '0;
                            state_q <= WAITING_MEMORY_A;
                            if (j_q == n_m1) begin
                                j_q <= '0;
                                if (i_q == n_m1) begin
                                    i_q     <= '0;
                                    state_q <= IDLE;
                                    op_done <= 1'b1;
                                end else begin
                                    i_q <= i_q + 9'd1;
                                end
                            end else begin
                                j_q <= j_q + 9'd1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_write = 1'b0;
        mem_wdata = '0;
        case (state_q)
            WAITING_MEMORY_A: mem_addr = addr_A + ADDR_W'(a_idx);
            WAITING_MEMORY_B,
            COMPUTE:          mem_addr = addr_B + ADDR_W'(b_idx);
            WRITEBACK: begin
                mem_addr  = addr_C + ADDR_W'(c_idx);
                mem_write = adv & ~rst;
                mem_wdata = mac_result;
            end
            default: ;
        endcase
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer with a behavioural synchronous-read memory.
module tb_matmul_sequencer;
    import SystolicTypes::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst = 1'b0;
    logic        new_data = 1'b0;
    logic [11:0] addr_A = '0, addr_B = '0, addr_C = '0;
    logic [8:0]  matrix_N = '0;
    logic        stepping_enable = 1'b0;
    logic        step = 1'b0;
    logic [11:0] mem_addr;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    state_t      fsm_state;
    logic [15:0] cycle_count;
    logic [31:0] int_ops;
    logic        op_done;
    logic        overflow;

    logic [15:0] mem [4096];
    int          wr_count = 0;
    int          activity = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    matmul_sequencer #(.WIDTH(16), .ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .rst(rst), .new_data(new_data),
        .addr_A(addr_A), .addr_B(addr_B), .addr_C(addr_C), .matrix_N(matrix_N),
        .stepping_enable(stepping_enable), .step(step),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fsm_state(fsm_state), .cycle_count(cycle_count),
        .int_ops(int_ops), .op_done(op_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        if (mem_write || mem_addr != 12'd0) activity <= activity + 1;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct packed {
        int               n;
        logic [11:0]      ab, bb, cb;
        logic [0:3][15:0] a, b, c;
        logic             ovf;
        logic [15:0]      cyc;
        logic [31:0]      ops;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_job(input vec_t v);
        for (int e = 0; e < v.n * v.n; e++) begin
            mem[int'(v.ab) + e] = v.a[e];
            mem[int'(v.bb) + e] = v.b[e];
            mem[int'(v.cb) + e] = 16'hDEAD;
        end
        @(negedge clk);
        matrix_N = 9'(v.n);
        addr_A = v.ab; addr_B = v.bb; addr_C = v.cb;
        wr_count = 0;
        new_data = 1'b1;
        @(negedge clk);
        new_data = 1'b0;
    endtask

    task automatic finish_job(input vec_t v, input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (op_done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check({tag, "_state_idle"}, 64'(fsm_state), 64'(IDLE));
        check({tag, "_cycle_count"}, 64'(cycle_count), 64'(v.cyc));
        check({tag, "_int_ops"}, 64'(int_ops), 64'(v.ops));
        check({tag, "_overflow"}, 64'(overflow), 64'(v.ovf));
        check({tag, "_writes"}, 64'(wr_count), 64'(v.n * v.n));
        for (int e = 0; e < v.n * v.n; e++)
            check($sformatf("%s_C%0d", tag, e), 64'(mem[int'(v.cb) + e]), 64'(v.c[e]));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        start_job(v);
        check({tag, "_first_state"}, 64'(fsm_state), 64'(WAITING_MEMORY_A));
        check({tag, "_first_addr"}, 64'(mem_addr), 64'(v.ab));
        finish_job(v, tag);
    endtask

    initial begin
        bit found;
        vecs[0] = '{n: 2, ab: 12'd0,   bb: 12'd16,  cb: 12'd32,
                    a: {16'd1, 16'd2, 16'd3, 16'd4}, b: {16'd5, 16'd6, 16'd7, 16'd8},
                    c: {16'd19, 16'd22, 16'd43, 16'd50}, ovf: 1'b0, cyc: 16'd28, ops: 32'd16};
        vecs[1] = '{n: 1, ab: 12'd100, bb: 12'd101, cb: 12'd102,
                    a: {16'hFFFF, 16'd0, 16'd0, 16'd0}, b: {16'd2, 16'd0, 16'd0, 16'd0},
                    c: {16'hFFFF, 16'd0, 16'd0, 16'd0}, ovf: 1'b1, cyc: 16'd4, ops: 32'd2};
        vecs[2] = '{n: 1, ab: 12'd200, bb: 12'd201, cb: 12'd202,
                    a: {16'd7, 16'd0, 16'd0, 16'd0}, b: {16'd9, 16'd0, 16'd0, 16'd0},
                    c: {16'd63, 16'd0, 16'd0, 16'd0}, ovf: 1'b0, cyc: 16'd4, ops: 32'd2};
        vecs[3] = '{n: 2, ab: 12'd300, bb: 12'd310, cb: 12'd320,
                    a: {16'd1, 16'd0, 16'd0, 16'd1}, b: {16'd9, 16'd8, 16'd7, 16'd6},
                    c: {16'd9, 16'd8, 16'd7, 16'd6}, ovf: 1'b0, cyc: 16'd28, ops: 32'd16};
        vecs[4] = '{n: 2, ab: 12'd400, bb: 12'd410, cb: 12'd420,
                    a: {16'h0100, 16'd0, 16'd0, 16'd1}, b: {16'h0100, 16'd3, 16'd0, 16'd5},
                    c: {16'hFFFF, 16'h0300, 16'd0, 16'd5}, ovf: 1'b1, cyc: 16'd28, ops: 32'd16};

        for (int e = 0; e < 4096; e++) mem[e] = '0;

        repeat (3) @(negedge clk);
        check("rst_state", 64'(fsm_state), 64'(IDLE));
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_write", 64'(mem_write), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_cycles", 64'(cycle_count), 64'd0);
        check("rst_ops", 64'(int_ops), 64'd0);
        check("rst_done", 64'(op_done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 5; t++) run_vec(vecs[t], $sformatf("vec%0d", t));

        // Async reset during COMPUTE of element 1.
        start_job(vecs[0]);
        found = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (fsm_state == COMPUTE && wr_count == 1) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("areset_reached", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_state", 64'(fsm_state), 64'(IDLE));
        check("areset_addr", 64'(mem_addr), 64'd0);
        check("areset_write", 64'(mem_write), 64'd0);
        check("areset_cycles", 64'(cycle_count), 64'd0);
        check("areset_ops", 64'(int_ops), 64'd0);
        check("areset_done", 64'(op_done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("areset_no_more_writes", 64'(wr_count), 64'd1);
        check("areset_stays_idle", 64'(fsm_state), 64'(IDLE));
        run_vec(vecs[0], "after_areset");

        // Soft reset mid-job, then soft reset coinciding with a new request edge.
        start_job(vecs[3]);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("srst_state", 64'(fsm_state), 64'(IDLE));
        check("srst_cycles", 64'(cycle_count), 64'd0);
        check("srst_ops", 64'(int_ops), 64'd0);
        rst = 1'b1; new_data = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("srst_wins_state", 64'(fsm_state), 64'(IDLE));
        new_data = 1'b0;
        @(negedge clk);

        // Held request starts exactly one job.
        for (int e = 0; e < 3; e++) mem[500 + e] = 16'(e + 3);
        matrix_N = 9'd1; addr_A = 12'd500; addr_B = 12'd501; addr_C = 12'd502;
        wr_count = 0;
        new_data = 1'b1;
        repeat (100) @(negedge clk);
        new_data = 1'b0;
        repeat (5) @(negedge clk);
        check("held_writes", 64'(wr_count), 64'd1);
        check("held_done", 64'(op_done), 64'd1);
        check("held_cycles", 64'(cycle_count), 64'd4);
        check("held_C", 64'(mem[502]), 64'd12);

        // N == 0 request is ignored; op_done stays as left by the previous job.
        matrix_N = 9'd0; addr_A = 12'd7; addr_B = 12'd8; addr_C = 12'd9;
        wr_count = 0; activity = 0;
        new_data = 1'b1;
        repeat (10) @(negedge clk);
        new_data = 1'b0;
        check("n0_state", 64'(fsm_state), 64'(IDLE));
        check("n0_writes", 64'(wr_count), 64'd0);
        check("n0_activity", 64'(activity), 64'd0);
        check("n0_done_kept", 64'(op_done), 64'd1);

`ifdef STEPPING_EN
        for (int e = 0; e < 3; e++) mem[600 + e] = 16'(e + 4);
        mem[602] = 16'hDEAD;
        stepping_enable = 1'b1;
        matrix_N = 9'd1; addr_A = 12'd600; addr_B = 12'd601; addr_C = 12'd602;
        wr_count = 0;
        new_data = 1'b1;
        @(negedge clk);
        new_data = 1'b0;
        repeat (10) @(negedge clk);
        check("step_stuck_state", 64'(fsm_state), 64'(WAITING_MEMORY_A));
        check("step_stuck_addr", 64'(mem_addr), 64'd600);
        for (int s = 0; s < 4; s++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (2) @(negedge clk);
        end
        check("step_writes", 64'(wr_count), 64'd1);
        check("step_done", 64'(op_done), 64'd1);
        check("step_C", 64'(mem[602]), 64'd20);
        stepping_enable = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

- Executes one unsigned N×N matrix multiply C = A·B against the shared 4096×WIDTH data memory, one multiply-accumulate per element step.
- Sits directly downstream of the control/status module:
  - Consumes its start, soft-reset, base-address and N outputs.
  - Returns the FSM state, cycle count, op count, done and overflow flags that the control module reports.

## Interface
Parameters:
- WIDTH, 16, data word width (memory and C elements)
- ADDR_W, 12, memory address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rst  in  1  synchronous soft reset from control
- new_data  in  1  job request (level; edge-detected here)
- addr_A, addr_B, addr_C  in  ADDR_W  row-major base addresses
- matrix_N  in  9  matrix dimension
- stepping_enable, step  in  1  single-step controls
- mem_addr  out  ADDR_W  memory address
- mem_write  out  1  memory write strobe
- mem_wdata  out  WIDTH  write data
- mem_rdata  in  WIDTH  read data, valid one cycle after mem_addr (synchronous read)
- fsm_state  out  state_t  current state
- cycle_count  out  16  cycles spent outside IDLE in current/last job
- int_ops  out  32  integer ops of current/last job
- op_done  out  1  last job completed
- overflow  out  1  sticky: some C element saturated in current/last job

## Operation
- States: IDLE, WAITING_MEMORY_A, WAITING_MEMORY_B, COMPUTE, WRITEBACK.
- Job start: IDLE, new_data rising edge (new_data & ~new_data_q), matrix_N != 0. On start:
  - Clear i, j, k, accumulator, cycle_count, int_ops, overflow and op_done.
  - Go to WAITING_MEMORY_A.
- matrix_N == 0 at start: ignored; stay IDLE, flags unchanged.
- WAITING_MEMORY_A: mem_addr = addr_A + i·N + k; then WAITING_MEMORY_B.
- WAITING_MEMORY_B: mem_addr = addr_B + k·N + j. On the first cycle of each visit, a_reg ← mem_rdata. Then COMPUTE.
- COMPUTE: mem_addr holds the B address. On exit:
  - acc ← acc + a_reg·mem_rdata.
  - int_ops += 2.
  - If k < N−1: k++ and go to WAITING_MEMORY_A; otherwise go to WRITEBACK.
- WRITEBACK (one cycle):
  - mem_write = 1, mem_addr = addr_C + i·N + j.
  - mem_wdata = acc if acc ≤ 2^WIDTH−1; otherwise all-ones, and overflow ← 1.
  - Then clear acc and k, and advance j (then i).
  - After the last element, go to IDLE and set op_done = 1.
- Arithmetic:
  - Index products use 14 bits.
  - Address sums truncate modulo 2^ADDR_W (bounds are checked upstream).
  - Accumulator is 2·WIDTH+8 bits and cannot wrap for N ≤ 128.
- cycle_count: increments every non-IDLE cycle and saturates at 0xFFFF.
- mem_write is 0 outside WRITEBACK; mem_addr is 0 in IDLE.
- new_data held high starts exactly one job. Another edge arriving while busy is ignored.
- rst (sync) or rst_n (async) mid-job:
  - Abort to IDLE, no further write.
  - All outputs and counters return to reset values.

## Timing
- Reset values: fsm_state IDLE; mem_addr, mem_write, mem_wdata, cycle_count, int_ops, op_done, overflow all 0.
- First memory address appears the cycle after the start edge is sampled.
- Per element: 3N+1 cycles. Job: N²·(3N+1) cycles (N=2 → 28).
- op_done rises the same edge the FSM returns to IDLE, and stays high until the next job start or reset.
- rst and new_data edge in the same cycle: rst wins.

## Configuration
- STEPPING_EN defined:
  - With stepping_enable = 1, non-IDLE states advance only on a cycle with a step rising edge; otherwise the state and all memory outputs hold.
  - WRITEBACK asserts mem_write only on its advancing cycle.
  - cycle_count still counts every non-IDLE cycle.
- STEPPING_EN undefined: stepping_enable and step are ignored; free-running.

## Structure
- Package SystolicTypes holds state_t, ADDR_W default, ACC_W = 2·WIDTH+8 and MEM_DEPTH = 4096.
- Sub-module mac_unit:
  - Accumulator with clear and enable inputs.
  - Saturating WIDTH-bit output plus a saturated flag.

## Test plan
- Normal multiply: N=2, A@0=[1,2,3,4], B@16=[5,6,7,8], C@32 → writes [19,22,43,50] at 32..35; op_done=1, cycle_count=28, int_ops=16, overflow=0.
- Saturation: N=1, A=0xFFFF, B=2 → C=0xFFFF, overflow=1, cycle_count=4, int_ops=2.
- Async reset: rst_n pulsed low during COMPUTE of element 1 (N=2) → outputs 0 immediately, no further mem_write; the next job produces correct results.
- Held request: new_data high for 100 cycles, N=1 → exactly one mem_write pulse, a single job.
- Stepping (STEPPING_EN defined): stepping_enable=1, N=1, no step → fsm_state stuck in WAITING_MEMORY_A; 4 step pulses → one write, op_done=1.
- Invalid N: N=0 with a new_data edge → FSM stays IDLE, no memory activity, op_done unchanged.
